// File: rtl/fgyrus_pcm_pkg.sv
// Shared types for the fgyrus PCM fetch path: FSM state, stream tag, frame size.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package fgyrus_pcm_pkg;

    // Buffer address width the stream tag is sized for; the top's address
    // parameter defaults to this and must stay equal to it.
    localparam int PCM_ADDR_W      = 8;
    localparam int PCM_FRAME_WORDS = 1 << PCM_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic                    chnl;
        logic [PCM_ADDR_W-2:0]   idx;
        logic                    sof;
        logic                    eof;
    } samp_tag_t;

    // Buffer is left/right interleaved: bit 0 picks the channel, the rest is
    // the sample index; first and last buffer words bound the frame.
    function automatic samp_tag_t addr_to_tag(input logic [PCM_ADDR_W-1:0] addr);
        samp_tag_t tag;
        tag.chnl = addr[0];
        tag.idx  = addr[PCM_ADDR_W-1:1];
        tag.sof  = (addr == '0);
        tag.eof  = (addr == '1);
        return tag;
    endfunction

endpackage

// File: rtl/fgyrus_pcm_fetch_fifo.sv
// Small synchronous FIFO holding returned PCM words with their tags.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: push is ignored when full (never happens in use), pop ignored when empty.
//
// Ports: clk/rst_n (async active-low), push/push_data in, pop in,
//        head_data out (entry at read pointer), count/empty/full out.
module fgyrus_pcm_fetch_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    // Storage is reset so the head (and every output fed from it) reads 0 in reset.
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Upstream credit accounting guarantees a slot for every read in flight.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/fgyrus_pcm_fetch.sv
// Fetches the full acortex PCM buffer on each new-frame edge and streams it out tagged.
// Latency: edge in cycle T -> address 0 at T+1 -> first (sof) word valid at T+2+RD_LAT.
// Backpressure: reads issue only while in-flight + FIFO occupancy < FIFO_DEPTH; stalled
//               output holds valid and data stable until ready.
//
// Ports: fgyrus_clk / fgyrus_rst_n; acortex2fgyrus_pcm_rdy (frame level), fgyrus2acortex_addr
//        and acortex2fgyrus_pcm_data (sync-read memory port); pcm_samp_* valid/ready stream
//        with chnl/idx/sof/eof tags; pcm_fetch_busy and pcm_ovrn_pulse status.
module fgyrus_pcm_fetch
    import fgyrus_pcm_pkg::*;
#(
    parameter int PCM_MEM_DATA_W = 32,
    parameter int PCM_MEM_ADDR_W = PCM_ADDR_W,
    parameter int RD_LAT         = 2,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      fgyrus_clk,
    input  logic                      fgyrus_rst_n,
    input  logic                      acortex2fgyrus_pcm_rdy,
    output logic [PCM_MEM_ADDR_W-1:0] fgyrus2acortex_addr,
    input  logic [PCM_MEM_DATA_W-1:0] acortex2fgyrus_pcm_data,
    output logic                      pcm_samp_valid,
    input  logic                      pcm_samp_ready,
    output logic [PCM_MEM_DATA_W-1:0] pcm_samp_data,
    output logic                      pcm_samp_chnl,
    output logic [PCM_MEM_ADDR_W-2:0] pcm_samp_idx,
    output logic                      pcm_samp_sof,
    output logic                      pcm_samp_eof,
    output logic                      pcm_fetch_busy,
    output logic                      pcm_ovrn_pulse
);

    localparam int TAG_W  = $bits(samp_tag_t);
    localparam int ENT_W  = PCM_MEM_DATA_W + TAG_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int FLT_W  = $clog2(RD_LAT + 1);

    fetch_state_t                state;
    logic                        rdy_d;
    logic                        rdy_edge;
    logic [PCM_MEM_ADDR_W-1:0]   rd_addr;
    logic                        busy;
    logic                        ovrn;

    logic [RD_LAT-1:0]           ret_vld;
    samp_tag_t                   ret_tag [RD_LAT];
    logic [FLT_W-1:0]            in_flight;

    logic                        issue;
    logic                        ret;
    logic                        credit_ok;
    logic                        pop;
    logic                        drain_done;

    logic [ENT_W-1:0]            fifo_head;
    logic [CNT_W-1:0]            fifo_count;
    logic                        fifo_empty;
    logic                        fifo_full;
    samp_tag_t                   head_tag;

    assign rdy_edge  = acortex2fgyrus_pcm_rdy & ~rdy_d;
    assign credit_ok = (int'(in_flight) + int'(fifo_count)) < FIFO_DEPTH;
    assign issue     = (state == ST_FETCH) && credit_ok;
    assign ret       = ret_vld[RD_LAT-1];
    assign pop       = pcm_samp_valid & pcm_samp_ready;
    // Leave DRAIN in the same cycle the last word pops so busy drops right after eof.
    assign drain_done = (in_flight == '0) &&
                        ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

    // FSM with registered address, busy and overrun outputs.
    always_ff @(posedge fgyrus_clk or negedge fgyrus_rst_n) begin
        if (!fgyrus_rst_n) begin
            state   <= ST_IDLE;
            rdy_d   <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
            ovrn    <= 1'b0;
        end else begin
            rdy_d <= acortex2fgyrus_pcm_rdy;
            // busy is the registered flag, so an edge in the cycle busy falls is an overrun.
            ovrn  <= rdy_edge & busy;
            case (state)
                ST_IDLE: begin
                    if (rdy_edge) begin
                        state   <= ST_FETCH;
                        rd_addr <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (issue) begin
                        if (rd_addr == '1) begin
                            state   <= ST_DRAIN;
                            rd_addr <= '0;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    rd_addr <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Return pipeline: marks the cycle each issued read's data is on the bus.
    always_ff @(posedge fgyrus_clk or negedge fgyrus_rst_n) begin
        if (!fgyrus_rst_n) begin
            ret_vld   <= '0;
            in_flight <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                ret_tag[i] <= '0;
            end
        end else begin
            ret_vld[0] <= issue;
            ret_tag[0] <= addr_to_tag(rd_addr);
            for (int i = 1; i < RD_LAT; i++) begin
                ret_vld[i] <= ret_vld[i-1];
                ret_tag[i] <= ret_tag[i-1];
            end
            case ({issue, ret})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    fgyrus_pcm_fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (fgyrus_clk),
        .rst_n     (fgyrus_rst_n),
        .push      (ret),
        .push_data ({acortex2fgyrus_pcm_data, ret_tag[RD_LAT-1]}),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign {pcm_samp_data, head_tag} = fifo_head;
    assign pcm_samp_valid      = ~fifo_empty;
    assign pcm_samp_chnl       = head_tag.chnl;
    assign pcm_samp_idx        = head_tag.idx;
    assign pcm_samp_sof        = head_tag.sof;
    assign pcm_samp_eof        = head_tag.eof;
    assign fgyrus2acortex_addr = rd_addr;
    assign pcm_fetch_busy      = busy;
    assign pcm_ovrn_pulse      = ovrn;

endmodule

// File: tb/tb_fgyrus_pcm_fetch.sv
module tb_fgyrus_pcm_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic [7:0]  addr;
    logic [31:0] mem_data;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic        chnl;
    logic [6:0]  idx;
    logic        sof;
    logic        eof;
    logic        busy;
    logic        ovrn;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fgyrus_pcm_fetch dut (
        .fgyrus_clk              (clk),
        .fgyrus_rst_n            (rst_n),
        .acortex2fgyrus_pcm_rdy  (rdy),
        .fgyrus2acortex_addr     (addr),
        .acortex2fgyrus_pcm_data (mem_data),
        .pcm_samp_valid          (valid),
        .pcm_samp_ready          (ready),
        .pcm_samp_data           (data),
        .pcm_samp_chnl           (chnl),
        .pcm_samp_idx            (idx),
        .pcm_samp_sof            (sof),
        .pcm_samp_eof            (eof),
        .pcm_fetch_busy          (busy),
        .pcm_ovrn_pulse          (ovrn)
    );

    // Memory model: word i = mem_base + i, data two cycles after the address.
    logic [31:0] mem_base;
    logic [31:0] pipe0, pipe1;
    always @(posedge clk) begin
        pipe0 <= mem_base + {24'd0, addr};
        pipe1 <= pipe0;
    end
    assign mem_data = pipe1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state
    int          word_cnt, word_err, ahead_err, stab_err;
    int          ovrn_cnt, ovrn_run, ovrn_max, valid_seen, busy_seen;
    int          sof_cyc, eof_cyc, busy_fall_cyc;
    logic [31:0] last_dat;
    logic        last_chnl;
    logic [6:0]  last_idx;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_dat;
    logic [9:0]  hold_tag;
    logic        busy_prev = 1'b0;
    int          t_edge;
    logic [7:0]  addr_t1, addr_t2;
    logic        timed_out;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        word_cnt = 0; word_err = 0; ahead_err = 0; stab_err = 0;
        ovrn_cnt = 0; ovrn_run = 0; ovrn_max = 0; valid_seen = 0; busy_seen = 0;
        sof_cyc = -1; eof_cyc = -1; busy_fall_cyc = -1;
        last_dat = '0; last_chnl = 1'b0; last_idx = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) valid_seen++;
            if (busy) busy_seen++;
            if (ovrn) begin
                ovrn_cnt++;
                ovrn_run++;
                if (ovrn_run > ovrn_max) ovrn_max = ovrn_run;
            end else begin
                ovrn_run = 0;
            end
            if (hold_pend && (!valid || data !== hold_dat || {chnl, idx, sof, eof} !== hold_tag))
                stab_err++;
            hold_pend = valid && !ready;
            hold_dat  = data;
            hold_tag  = {chnl, idx, sof, eof};
            if (busy && int'(addr) > word_cnt + 4) ahead_err++;
            if (valid && ready) begin
                if (data !== mem_base + word_cnt
                    || chnl !== word_cnt[0]
                    || int'(idx) != ((word_cnt >> 1) & 127)
                    || sof !== (word_cnt == 0)
                    || eof !== (word_cnt == 255))
                    word_err++;
                if (sof) sof_cyc = cyc;
                if (eof) begin
                    eof_cyc   = cyc;
                    last_dat  = data;
                    last_chnl = chnl;
                    last_idx  = idx;
                end
                word_cnt++;
            end
            if (busy_prev && !busy) busy_fall_cyc = cyc;
            busy_prev = busy;
        end else begin
            hold_pend = 1'b0;
            busy_prev = 1'b0;
        end
    end

    // mode 0: ready high; 1: random ready ~30%; 2: second rdy edge at word 100;
    // 3: stop at word 50 so the caller can pull reset.
    task automatic run_frame(input int mode, input logic [31:0] base);
        int ov_fired;
        rdy   = 1'b0;
        ready = (mode == 1) ? 1'b0 : 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        mem_base = base;
        clr_mon();
        rdy       = 1'b1;
        t_edge    = cyc;
        ov_fired  = 0;
        timed_out = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk); #1;
            if (k == 0) addr_t1 = addr;
            if (k == 1) addr_t2 = addr;
            if (mode == 1) ready = ($urandom_range(0, 9) < 3);
            if (mode == 2) begin
                if (k == 5) rdy = 1'b0;
                if (ov_fired == 0 && word_cnt >= 100) begin
                    rdy = 1'b1;
                    ov_fired = 1;
                end
            end
            if (mode == 3 && word_cnt >= 50) begin timed_out = 1'b0; break; end
            if (busy_fall_cyc >= 0) begin timed_out = 1'b0; break; end
        end
        chk("frame_timeout", timed_out, 0);
    endtask

    initial begin
        rst_n = 1'b1; rdy = 1'b0; ready = 1'b0; mem_base = 32'hA000_0000;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_addr",  addr, 0);
        chk("rst_valid", valid, 0);
        chk("rst_data",  data, 0);
        chk("rst_tags",  {chnl, idx, sof, eof}, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_ovrn",  ovrn, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clr_mon();
        repeat (20) @(posedge clk);
        #1;
        chk("idle_valid", valid_seen, 0);
        chk("idle_busy",  busy_seen, 0);

        // Basic frame
        run_frame(0, 32'hA000_0000);
        chk("f1_words",     word_cnt, 256);
        chk("f1_order",     word_err, 0);
        chk("f1_sof_lat",   sof_cyc - t_edge, 4);
        chk("f1_eof_lat",   eof_cyc - t_edge, 259);
        chk("f1_busy_fall", busy_fall_cyc - t_edge, 260);
        chk("f1_eof_data",  last_dat, 32'hA000_00FF);
        chk("f1_eof_chnl",  last_chnl, 1);
        chk("f1_eof_idx",   last_idx, 127);
        chk("f1_addr_t1",   addr_t1, 0);
        chk("f1_addr_t2",   addr_t2, 1);
        chk("f1_ovrn",      ovrn_cnt, 0);

        // Back-to-back: rdy low two cycles after the frame, then a new edge
        run_frame(0, 32'hB000_0000);
        chk("f2_words",   word_cnt, 256);
        chk("f2_order",   word_err, 0);
        chk("f2_sof_lat", sof_cyc - t_edge, 4);
        chk("f2_addr_t1", addr_t1, 0);
        chk("f2_addr_t2", addr_t2, 1);

        // Backpressure
        run_frame(1, 32'hC000_0000);
        chk("bp_words",  word_cnt, 256);
        chk("bp_order",  word_err, 0);
        chk("bp_ahead",  ahead_err, 0);
        chk("bp_stable", stab_err, 0);

        // Overrun at word 100
        run_frame(2, 32'hD000_0000);
        chk("ov_pulses", ovrn_cnt, 1);
        chk("ov_width",  ovrn_max, 1);
        chk("ov_words",  word_cnt, 256);
        chk("ov_order",  word_err, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("ov_no_2nd_busy",  busy, 0);
        chk("ov_no_2nd_words", word_cnt, 256);

        // Reset mid-frame
        run_frame(3, 32'hE000_0000);
        rst_n = 1'b0;
        rdy   = 1'b0;
        #1;
        chk("mr_valid", valid, 0);
        chk("mr_busy",  busy, 0);
        chk("mr_addr",  addr, 0);
        chk("mr_data",  data, 0);
        chk("mr_tags",  {chnl, idx, sof, eof}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame(0, 32'hF000_0000);
        chk("mr_words",   word_cnt, 256);
        chk("mr_order",   word_err, 0);
        chk("mr_sof_lat", sof_cyc - t_edge, 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
